// File: rtl/vlog_tap_parser.sv
// TAP text-stream parser: one ASCII byte per cycle, tracks plan and ok/not ok results.
// Updates are visible the cycle after the committing byte; never backpressures (ready stays high after reset).
module vlog_tap_parser #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_plan_valid,
  output logic [CNT_W-1:0] o_plan_count,
  output logic [CNT_W-1:0] o_tc_count,
  output logic [CNT_W-1:0] o_pass_count,
  output logic [CNT_W-1:0] o_fail_count,
  output logic             o_result_valid,
  output logic             o_result_ok,
  output logic [CNT_W-1:0] o_result_num,
  output logic             o_err_syntax,
  output logic             o_err_seq,
  output logic             o_err_plan,
  output logic             o_err_ovf,
  output logic             o_done,
  output logic             o_all_pass
);

  localparam int             AW    = CNT_W + 4;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_DOT  = 8'h2E;
  localparam logic [7:0] CH_ONE  = 8'h31;
  localparam logic [7:0] CH_K    = 8'h6B;
  localparam logic [7:0] CH_N    = 8'h6E;
  localparam logic [7:0] CH_O    = 8'h6F;
  localparam logic [7:0] CH_T    = 8'h74;

  typedef enum logic [3:0] {
    S_LINE_START, S_PLAN_D1, S_PLAN_D2, S_PLAN_NUM,
    S_NOT_O, S_NOT_T, S_NOT_SP, S_OK_O, S_OK_K, S_OK_SP,
    S_TC_NUM, S_SKIP, S_BAD
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_acc;
  logic             r_have_digit;
  logic             r_neg;
  logic             r_plan_valid;
  logic [CNT_W-1:0] r_plan_count;
  logic [CNT_W-1:0] r_tc_count;
  logic [CNT_W-1:0] r_pass_count;
  logic [CNT_W-1:0] r_fail_count;
  logic             r_result_valid;
  logic             r_result_ok;
  logic [CNT_W-1:0] r_result_num;
  logic             r_err_syntax;
  logic             r_err_seq;
  logic             r_err_plan;
  logic             r_err_ovf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             w_accept;
  logic             w_is_lf;
  logic             w_is_sp;
  logic             w_is_digit;
  logic [AW-1:0]    w_acc_ext;
  logic             w_acc_ovf;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W:0]   w_tc_inc;
  logic [CNT_W-1:0] w_tc_next;
  state_t           w_bad_state;

  // CR is swallowed here so no state ever sees it.
  assign w_accept    = i_in_valid && r_in_ready && (i_in_data != CH_CR);
  assign w_is_lf     = (i_in_data == CH_LF);
  assign w_is_sp     = (i_in_data == CH_SP);
  assign w_is_digit  = (i_in_data >= 8'h30) && (i_in_data <= 8'h39);
  assign w_acc_ext   = {4'd0, r_acc} * AW'(10) + AW'(i_in_data[3:0]);
  assign w_acc_ovf   = (w_acc_ext > AW'(MAX));
  assign w_acc_next  = w_acc_ovf ? MAX : w_acc_ext[CNT_W-1:0];
  assign w_tc_inc    = {1'b0, r_tc_count} + (CNT_W+1)'(1);
  assign w_tc_next   = sat_inc(r_tc_count);
  // An unexpected LF already ends the line, so there is nothing left to skip.
  assign w_bad_state = w_is_lf ? S_LINE_START : S_BAD;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_LINE_START;
      r_in_ready     <= 1'b0;
      r_acc          <= '0;
      r_have_digit   <= 1'b0;
      r_neg          <= 1'b0;
      r_plan_valid   <= 1'b0;
      r_plan_count   <= '0;
      r_tc_count     <= '0;
      r_pass_count   <= '0;
      r_fail_count   <= '0;
      r_result_valid <= 1'b0;
      r_result_ok    <= 1'b0;
      r_result_num   <= '0;
      r_err_syntax   <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_plan     <= 1'b0;
      r_err_ovf      <= 1'b0;
    end else if (i_clr) begin
      r_state        <= S_LINE_START;
      r_in_ready     <= 1'b0;
      r_acc          <= '0;
      r_have_digit   <= 1'b0;
      r_neg          <= 1'b0;
      r_plan_valid   <= 1'b0;
      r_plan_count   <= '0;
      r_tc_count     <= '0;
      r_pass_count   <= '0;
      r_fail_count   <= '0;
      r_result_valid <= 1'b0;
      r_result_ok    <= 1'b0;
      r_result_num   <= '0;
      r_err_syntax   <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_plan     <= 1'b0;
      r_err_ovf      <= 1'b0;
    end else begin
      r_in_ready     <= 1'b1;
      r_result_valid <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_LINE_START: begin
            r_acc        <= '0;
            r_have_digit <= 1'b0;
            r_neg        <= (i_in_data == CH_N);
            case (i_in_data)
              CH_ONE:  r_state <= S_PLAN_D1;
              CH_O:    r_state <= S_OK_K;
              CH_N:    r_state <= S_NOT_O;
              CH_HASH: r_state <= S_SKIP;
              CH_LF:   r_state <= S_LINE_START;
              default: begin
                r_state      <= S_BAD;
                r_err_syntax <= 1'b1;
              end
            endcase
          end
          S_PLAN_D1, S_PLAN_D2: begin
            if (i_in_data == CH_DOT) begin
              r_state <= (r_state == S_PLAN_D1) ? S_PLAN_D2 : S_PLAN_NUM;
            end else begin
              r_state      <= w_bad_state;
              r_err_syntax <= 1'b1;
            end
          end
          S_PLAN_NUM: begin
            if (w_is_digit) begin
              r_acc        <= w_acc_next;
              r_have_digit <= 1'b1;
              if (w_acc_ovf) r_err_ovf <= 1'b1;
            end else if (w_is_lf && r_have_digit) begin
              r_state <= S_LINE_START;
              if (r_plan_valid) begin
                r_err_plan <= 1'b1;
              end else begin
                r_plan_valid <= 1'b1;
                r_plan_count <= r_acc;
              end
            end else begin
              r_state      <= w_bad_state;
              r_err_syntax <= 1'b1;
            end
          end
          S_NOT_O, S_NOT_T, S_NOT_SP, S_OK_O, S_OK_K, S_OK_SP: begin
            if      (r_state == S_NOT_O  && i_in_data == CH_O) r_state <= S_NOT_T;
            else if (r_state == S_NOT_T  && i_in_data == CH_T) r_state <= S_NOT_SP;
            else if (r_state == S_NOT_SP && w_is_sp)           r_state <= S_OK_O;
            else if (r_state == S_OK_O   && i_in_data == CH_O) r_state <= S_OK_K;
            else if (r_state == S_OK_K   && i_in_data == CH_K) r_state <= S_OK_SP;
            else if (r_state == S_OK_SP  && w_is_sp)           r_state <= S_TC_NUM;
            else begin
              r_state      <= w_bad_state;
              r_err_syntax <= 1'b1;
            end
          end
          S_TC_NUM: begin
            if (w_is_digit) begin
              r_acc        <= w_acc_next;
              r_have_digit <= 1'b1;
              if (w_acc_ovf) r_err_ovf <= 1'b1;
            end else if ((w_is_sp || w_is_lf) && r_have_digit) begin
              r_state        <= w_is_lf ? S_LINE_START : S_SKIP;
              r_tc_count     <= w_tc_next;
              r_result_valid <= 1'b1;
              r_result_ok    <= !r_neg;
              r_result_num   <= r_acc;
              if (r_neg) r_fail_count <= sat_inc(r_fail_count);
              else       r_pass_count <= sat_inc(r_pass_count);
              if ({1'b0, r_acc} != w_tc_inc) r_err_seq <= 1'b1;
              if (r_plan_valid && (w_tc_next > r_plan_count)) r_err_plan <= 1'b1;
            end else begin
              r_state      <= w_bad_state;
              r_err_syntax <= 1'b1;
            end
          end
          S_SKIP, S_BAD: begin
            if (w_is_lf) r_state <= S_LINE_START;
          end
          default: r_state <= S_LINE_START;
        endcase
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_plan_valid   = r_plan_valid;
  assign o_plan_count   = r_plan_count;
  assign o_tc_count     = r_tc_count;
  assign o_pass_count   = r_pass_count;
  assign o_fail_count   = r_fail_count;
  assign o_result_valid = r_result_valid;
  assign o_result_ok    = r_result_ok;
  assign o_result_num   = r_result_num;
  assign o_err_syntax   = r_err_syntax;
  assign o_err_seq      = r_err_seq;
  assign o_err_plan     = r_err_plan;
  assign o_err_ovf      = r_err_ovf;
  assign o_done         = r_plan_valid && (r_tc_count == r_plan_count);
  assign o_all_pass     = o_done && (r_fail_count == '0) && !r_err_syntax &&
                          !r_err_seq && !r_err_plan && !r_err_ovf;

endmodule

// File: tb/tb_vlog_tap_parser.sv
// Bench for vlog_tap_parser: directed TAP streams from a table, reset/clear corner cases,
// and random lines checked against a line-level model of the TAP rules.
module tb_vlog_tap_parser;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_clr = 1'b0;
  logic [7:0]   i_in_data = 8'h00;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready, o_plan_valid, o_result_valid, o_result_ok;
  logic [W-1:0] o_plan_count, o_tc_count, o_pass_count, o_fail_count, o_result_num;
  logic         o_err_syntax, o_err_seq, o_err_plan, o_err_ovf, o_done, o_all_pass;

  always #5 clk = ~clk;

  vlog_tap_parser #(.CNT_W(W)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_clr(i_clr),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_plan_valid(o_plan_valid), .o_plan_count(o_plan_count),
    .o_tc_count(o_tc_count), .o_pass_count(o_pass_count), .o_fail_count(o_fail_count),
    .o_result_valid(o_result_valid), .o_result_ok(o_result_ok), .o_result_num(o_result_num),
    .o_err_syntax(o_err_syntax), .o_err_seq(o_err_seq), .o_err_plan(o_err_plan),
    .o_err_ovf(o_err_ovf), .o_done(o_done), .o_all_pass(o_all_pass)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W:0] got_q[$];
  logic [W:0] exp_q[$];

  always @(negedge clk) if (o_result_valid) got_q.push_back({o_result_ok, o_result_num});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- line-level reference model ----------------
  bit            m_pv, m_syn, m_seq, m_perr, m_ovf;
  int            m_plan, m_tc, m_pass, m_fail;
  byte unsigned  m_line[$];

  task automatic model_reset();
    m_pv = 0; m_syn = 0; m_seq = 0; m_perr = 0; m_ovf = 0;
    m_plan = 0; m_tc = 0; m_pass = 0; m_fail = 0;
    m_line.delete();
    exp_q.delete();
  endtask

  function automatic bit has_prefix(input byte unsigned q[$], input string p);
    if (q.size() < p.len()) return 0;
    for (int i = 0; i < p.len(); i++) if (q[i] != $unsigned(p[i])) return 0;
    return 1;
  endfunction

  task automatic parse_num(input byte unsigned s[$], input int start,
                           output int val, output int nd, output bit ovf);
    val = 0; nd = 0; ovf = 0;
    for (int i = start; i < s.size(); i++) begin
      if (s[i] < 8'h30 || s[i] > 8'h39) break;
      val = val * 10 + int'(s[i] - 8'h30);
      if (val > MAXV) begin val = MAXV; ovf = 1; end
      nd++;
    end
  endtask

  task automatic model_line(input byte unsigned s[$]);
    int val, nd, start;
    bit ovf, neg, tail_ok;
    logic [W:0] e;
    if (s.size() == 0) return;
    if (s[0] == 8'h23) return;
    if (has_prefix(s, "1..")) begin
      parse_num(s, 3, val, nd, ovf);
      if (ovf) m_ovf = 1;
      if (nd > 0 && 3 + nd == s.size()) begin
        if (m_pv) m_perr = 1;
        else begin m_pv = 1; m_plan = val; end
      end else m_syn = 1;
      return;
    end
    if (has_prefix(s, "ok ")) begin start = 3; neg = 0; end
    else if (has_prefix(s, "not ok ")) begin start = 7; neg = 1; end
    else begin m_syn = 1; return; end
    parse_num(s, start, val, nd, ovf);
    if (ovf) m_ovf = 1;
    tail_ok = (start + nd == s.size());
    if (start + nd < s.size()) tail_ok = (s[start + nd] == 8'h20);
    if (nd > 0 && tail_ok) begin
      if (val != m_tc + 1) m_seq = 1;
      m_tc = (m_tc < MAXV) ? m_tc + 1 : MAXV;
      if (neg) m_fail = (m_fail < MAXV) ? m_fail + 1 : MAXV;
      else     m_pass = (m_pass < MAXV) ? m_pass + 1 : MAXV;
      if (m_pv && m_tc > m_plan) m_perr = 1;
      e = {~neg, val[W-1:0]};
      exp_q.push_back(e);
    end else m_syn = 1;
  endtask

  task automatic model_byte(input byte unsigned b);
    if (b == 8'h0D) return;
    if (b == 8'h0A) begin model_line(m_line); m_line.delete(); end
    else m_line.push_back(b);
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input byte unsigned b);
    int t = 0;
    @(negedge clk);
    while (!o_in_ready && t < 20) begin @(negedge clk); t++; end
    if (!o_in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_wait: in_ready got 0, expected 1 within 20 cycles");
      return;
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    @(posedge clk);
    #1 i_in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {o_in_ready, o_plan_valid, o_plan_count, o_tc_count, o_pass_count,
                o_fail_count, o_result_valid, o_result_ok, o_result_num, o_err_syntax,
                o_err_seq, o_err_plan, o_err_ovf, o_done, o_all_pass}, 64'd0);
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    i_clr = 1'b1;
    @(negedge clk);
    check_zero(tag);
    i_clr = 1'b0;
    model_reset();
    got_q.delete();
  endtask

  task automatic check_model(input string tag);
    bit e_done;
    e_done = m_pv && (m_tc == m_plan);
    check({tag, "_ready"}, o_in_ready, 1);
    check({tag, "_plan_valid"}, o_plan_valid, m_pv);
    check({tag, "_plan_count"}, o_plan_count, m_plan);
    check({tag, "_tc_count"}, o_tc_count, m_tc);
    check({tag, "_pass_count"}, o_pass_count, m_pass);
    check({tag, "_fail_count"}, o_fail_count, m_fail);
    check({tag, "_errs"}, {o_err_syntax, o_err_seq, o_err_plan, o_err_ovf},
          {m_syn, m_seq, m_perr, m_ovf});
    check({tag, "_done"}, o_done, e_done);
    check({tag, "_all_pass"}, o_all_pass,
          e_done && m_fail == 0 && !m_syn && !m_seq && !m_perr && !m_ovf);
    check({tag, "_npulse"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_pulse%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         clr;
    string      stream;
    bit         pv;
    int         plan, tc, pass, fail;
    logic [3:0] err;     // {syntax, seq, plan, ovf}
    bit         done, ap;
    int         npulse, lastnum;
    bit         lastok;
  } vec_t;

  vec_t vecs[12];

  task automatic gen_line(output byte unsigned q[$]);
    string s, set, full;
    q.delete();
    set = "ok n1.# 9x";
    full = "not ok 7 - z";
    s = "";
    case ($urandom_range(0, 9))
      0, 1: s = $sformatf("ok %0d%s", m_tc + 1, ($urandom_range(0, 1) != 0) ? " - t" : "");
      2:    s = $sformatf("not ok %0d%s", m_tc + 1, ($urandom_range(0, 1) != 0) ? " # d" : "");
      3:    s = $sformatf("ok %0d", $urandom_range(0, 400));
      4:    s = $sformatf("1..%0d", $urandom_range(0, 300));
      5:    s = "# c x";
      6:    s = "";
      7:    for (int i = 0; i < int'($urandom_range(1, 5)); i++)
              q.push_back(set[$urandom_range(0, set.len() - 1)]);
      8:    s = full.substr(0, int'($urandom_range(0, full.len() - 1)));
      default: case ($urandom_range(0, 3))
        0: s = "ok 12x";
        1: s = "1..5 ";
        2: s = "not  ok 1";
        default: s = "ok 00001";
      endcase
    endcase
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if ($urandom_range(0, 3) == 0) q.insert($urandom_range(0, q.size()), 8'h0D);
  endtask

  initial begin
    byte unsigned line[$];
    vecs[0]  = '{1, "1..3\nok 1 - a\nnot ok 2 - b\nok 3\n", 1, 3, 3, 2, 1, 4'b0000, 1, 0, 3, 3, 1};
    vecs[1]  = '{1, "ok 1\nok 3\n1..2\n",                    1, 2, 2, 2, 0, 4'b0100, 1, 0, 2, 3, 1};
    vecs[2]  = '{1, "# hi\015\n\nfoo\nok\n1..1\nok 1\n",     1, 1, 1, 1, 0, 4'b1000, 1, 0, 1, 1, 1};
    vecs[3]  = '{1, "ok 300\n",                              0, 0, 1, 1, 0, 4'b0101, 0, 0, 1, 255, 1};
    vecs[4]  = '{0, "1..1\n1..2\nok 2\n",                    1, 1, 2, 2, 0, 4'b0111, 0, 0, 1, 2, 1};
    vecs[5]  = '{1, "1..2\015\nok 1\015\nnot ok 2 # x\n",    1, 2, 2, 1, 1, 4'b0000, 1, 0, 2, 2, 0};
    vecs[6]  = '{1, "1..2\nok 1\nok 2 - x\n",                1, 2, 2, 2, 0, 4'b0000, 1, 1, 2, 2, 1};
    vecs[7]  = '{1, "1..\nok\nok x\n1.2\nok  1\nok 1x\n2..3\n", 0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, "1..256\n",                              1, 255, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, "1..0\n",                                1, 0, 0, 0, 0, 4'b0000, 1, 1, 0, 0, 0};
    vecs[10] = '{0, "ok 1\n",                                1, 0, 1, 1, 0, 4'b0010, 0, 0, 1, 1, 1};
    vecs[11] = '{1, "not ok 1\n1..1\n",                      1, 1, 1, 0, 1, 4'b0000, 1, 0, 1, 1, 0};

    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    i_rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", o_in_ready, 1);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].clr) do_clr($sformatf("v%0d_clr", v));
      else begin got_q.delete(); exp_q.delete(); end
      send_str(vecs[v].stream);
      settle();
      check($sformatf("v%0d_plan_valid", v), o_plan_valid, vecs[v].pv);
      check($sformatf("v%0d_plan_count", v), o_plan_count, vecs[v].plan);
      check($sformatf("v%0d_tc_count", v), o_tc_count, vecs[v].tc);
      check($sformatf("v%0d_pass_count", v), o_pass_count, vecs[v].pass);
      check($sformatf("v%0d_fail_count", v), o_fail_count, vecs[v].fail);
      check($sformatf("v%0d_errs", v), {o_err_syntax, o_err_seq, o_err_plan, o_err_ovf}, vecs[v].err);
      check($sformatf("v%0d_done", v), o_done, vecs[v].done);
      check($sformatf("v%0d_all_pass", v), o_all_pass, vecs[v].ap);
      check($sformatf("v%0d_npulse", v), got_q.size(), vecs[v].npulse);
      if (vecs[v].npulse > 0 && got_q.size() > 0)
        check($sformatf("v%0d_last_pulse", v), got_q[got_q.size() - 1],
              {vecs[v].lastok, 8'(vecs[v].lastnum)});
      check_model($sformatf("v%0d_model", v));
    end

    // Reset asserted in the middle of a result line.
    do_clr("rst_pre_clr");
    send_str("not ok 1");
    @(negedge clk);
    i_rst_n = 1'b0;
    #1 check_zero("rst_mid_line");
    @(negedge clk);
    check_zero("rst_held");
    i_rst_n = 1'b1;
    model_reset();
    got_q.delete();
    send_str("1..1\nok 1\n");
    settle();
    check("rst_pass_count", o_pass_count, 1);
    check("rst_all_pass", o_all_pass, 1);
    check_model("rst_model");

    // Clear with a committing LF presented in the same cycle: the byte must be lost.
    do_clr("clr_pre_clr");
    send_str("not ok 1");
    @(negedge clk);
    i_clr = 1'b1;
    i_in_valid = 1'b1;
    i_in_data = 8'h0A;
    @(negedge clk);
    check_zero("clr_mid_line");
    i_clr = 1'b0;
    i_in_valid = 1'b0;
    model_reset();
    got_q.delete();
    send_str("1..1\nok 1\n");
    settle();
    check("clr_pass_count", o_pass_count, 1);
    check("clr_all_pass", o_all_pass, 1);
    check_model("clr_model");

    // Random lines against the model, with periodic clears.
    for (int n = 0; n < 240; n++) begin
      if (n % 30 == 0) do_clr($sformatf("rnd%0d_clr", n));
      gen_line(line);
      foreach (line[i]) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_byte(line[i]);
      end
      send_byte(8'h0A);
      settle();
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
